pixel_word_packer: RTL and testbench
====================================

# pixel_word_packer

Upstream feeder for the image-processing write path. It accepts a byte-wide pixel stream with a valid/ready handshake and packs four consecutive pixels into one 32-bit word. It writes each word into the frame BRAM using its own write address and write-enable, and it honours a `pause` stall from the address-generation stage. On completion it signals frame-done so the read side (address generator / `sm_top_module` path) can start consuming the frame.

## Interface
Parameters:
- `ADDR_W`, 12, width of the BRAM word address.
- `FRAME_PIXELS`, 16384, pixels per frame (128x128). Need not be a multiple of 4; legal range 1 .. 4*2^ADDR_W.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms a new frame; ignored unless idle.
- `pause` in 1: stall request from the address generator; while high, no pixel is accepted.
- `pix_in` in 8: pixel data.
- `pix_valid` in 1: `pix_in` is valid.
- `pix_ready` out 1: packer can accept a pixel this cycle.
- `W_BRAM_ADDR` out ADDR_W: BRAM word write address.
- `w_bram_din` out 32: packed word.
- `wea` out 1: BRAM write enable, one-cycle pulse per word.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the last word is written.

## Operation
- States: IDLE, PACK, DONE.
- IDLE: `pix_ready`=0, `busy`=0. When `start`=1, clear the pixel counter, byte lane and word address, then go to PACK.
- PACK: `busy`=1 and `pix_ready` = !`pause` (combinational from state and `pause`).
  - A pixel is accepted when `pix_valid` && `pix_ready`.
  - Accepted pixels fill lanes in arrival order: 1st to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
  - When lane 3 is filled, or the accepted pixel is pixel number FRAME_PIXELS (the last one), register the word to `w_bram_din` and pulse `wea`. Unfilled lanes of a partial final word are zero.
  - `W_BRAM_ADDR` holds the address of the word being written while `wea`=1. It increments by 1 in the cycle after each write.
  - After the write of the last pixel, go to DONE.
- DONE: pulse `frame_done` for exactly one cycle, then return to IDLE.
- `start` while busy is ignored. A `start` coinciding with the DONE cycle is also ignored.
- `pix_valid` outside PACK is ignored; no data is latched.
- Pixel counter width is $clog2(FRAME_PIXELS+1). Word address wraps modulo 2^ADDR_W, which is only reachable if the parameter is misconfigured.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `pix_ready`, `wea`, `busy`, `frame_done` = 0; `W_BRAM_ADDR` = 0; `w_bram_din` = 0; partial lane data cleared.
- `start` is sampled at edge T. `busy` and `pix_ready` are high from T+1, provided `pause`=0.
- The 4th pixel of a word is accepted at edge N. Then `wea`=1 and `w_bram_din` is valid in cycle N+1 (registered). The address increments at edge N+1.
- The packer sustains 1 pixel per cycle, i.e. 1 word per 4 cycles. `wea` never asserts on consecutive cycles unless FRAME_PIXELS<4 would force it, which is impossible.
- The last pixel is accepted at edge L. `wea` is high in cycle L+1, `frame_done` is high in cycle L+2, and `busy` falls at the end of cycle L+2.
- `pause` rising mid-word: `pix_ready` drops in the same cycle and partial lanes hold. A write already scheduled for the next cycle still occurs.
- `reset_n` low mid-frame aborts immediately. The partial word is discarded, no `wea` is issued, and a new `start` is required.

## Test plan
- Reset/idle: assert `reset_n`=0 mid-frame. All outputs go to 0 asynchronously. With `pix_valid`=1 and no `start`, `pix_ready` stays 0 and `wea` stays 0.
- Basic pack, FRAME_PIXELS=8: `start`, then pixels 0x11,0x22,...,0x88 back-to-back.
  - `wea` pulses 2 times: addr 0 data 0x44332211, then addr 1 data 0x88776655.
  - `frame_done` is high 2 cycles after the 8th acceptance.
- Partial final word, FRAME_PIXELS=6: pixels 0x01..0x06.
  - Writes 0x04030201 at addr 0 and 0x00000605 at addr 1.
- Pause/valid gaps: toggle `pause` and `pix_valid` randomly during an 8-pixel frame. `pix_ready`=0 whenever `pause`=1, and the written words are identical to the basic-pack scenario.
- `start` while busy: pulse `start` after 3 pixels. There is no counter or address clear; the frame completes normally with 2 writes.
- Full default frame (16384 pixels, incrementing mod 256):
  - Exactly 4096 `wea` pulses with addresses 0..4095; the last word is 0xFFFEFDFC.
  - Exactly one `frame_done` pulse.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Byte-stream to 32-bit word packer feeding the frame BRAM write port.
// Four pixels per word, little-endian lanes; frame_done after the last write.
module pixel_word_packer #(
  parameter int ADDR_W       = 12,
  parameter int FRAME_PIXELS = 16384
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] W_BRAM_ADDR,
  output logic [31:0]       w_bram_din,
  output logic              wea,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic [31:0]   lanes_q;
  logic [31:0]   word_nxt;
  logic          accept;
  logic          last_pix;
  logic          flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PACK;
      PACK: if (flush && last_pix) state_nxt = DONE;
      DONE: if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    pix_ready = (state == PACK) && !pause;
  end

  assign accept   = pix_valid && pix_ready;
  assign last_pix = (cnt == LAST);
  assign flush    = accept && ((lane == 2'd3) || last_pix);

  always_comb begin
    word_nxt = lanes_q;
    case (lane)
      2'd0:    word_nxt[7:0]   = pix_in;
      2'd1:    word_nxt[15:8]  = pix_in;
      2'd2:    word_nxt[23:16] = pix_in;
      default: word_nxt[31:24] = pix_in;
    endcase
  end

  // DONE lasts two cycles: the final write, then the frame_done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      lane        <= '0;
      lanes_q     <= '0;
      W_BRAM_ADDR <= '0;
      w_bram_din  <= '0;
      wea         <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wea        <= 1'b0;
      frame_done <= (state == DONE) && wea;
      if (wea) W_BRAM_ADDR <= W_BRAM_ADDR + 1'b1;
      if (state == IDLE && start) begin
        cnt         <= '0;
        lane        <= '0;
        lanes_q     <= '0;
        W_BRAM_ADDR <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        if (flush) begin
          w_bram_din <= word_nxt;
          wea        <= 1'b1;
          lane       <= '0;
          lanes_q    <= '0;
        end else begin
          lane    <= lane + 1'b1;
          lanes_q <= word_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench: three packer instances (8, 6, 16384 pixels) with a
// per-instance write scoreboard checked whenever wea pulses.
module tb_pixel_word_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_in = '0;
  logic [2:0]  st = '0;
  logic [2:0]  rdy, wea_v, bsy, fd;
  logic [11:0] adr [3];
  logic [31:0] din [3];

  int errors = 0;
  int checks = 0;

  logic [43:0] sb [3][$];

  always #5 clk = ~clk;

  pixel_word_packer #(.ADDR_W(12), .FRAME_PIXELS(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(st[0]), .pause(pause),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy[0]),
    .W_BRAM_ADDR(adr[0]), .w_bram_din(din[0]), .wea(wea_v[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  pixel_word_packer #(.ADDR_W(12), .FRAME_PIXELS(6)) u6 (
    .clk(clk), .reset_n(reset_n), .start(st[1]), .pause(pause),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy[1]),
    .W_BRAM_ADDR(adr[1]), .w_bram_din(din[1]), .wea(wea_v[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  pixel_word_packer u_full (
    .clk(clk), .reset_n(reset_n), .start(st[2]), .pause(pause),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy[2]),
    .W_BRAM_ADDR(adr[2]), .w_bram_din(din[2]), .wea(wea_v[2]),
    .busy(bsy[2]), .frame_done(fd[2]));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : mon
    int wcnt = 0;
    int fdcnt = 0;
    logic [43:0] e;
    always @(negedge clk) begin
      if (reset_n && wea_v[g] === 1'b1) begin
        wcnt++;
        if (sb[g].size() == 0) begin
          chk($sformatf("wea_unexpected_%0d", g), 64'd1, 64'd0);
        end else begin
          e = sb[g].pop_front();
          chk($sformatf("addr_%0d", g), 64'(adr[g]), 64'(e[43:32]));
          chk($sformatf("data_%0d", g), 64'(din[g]), 64'(e[31:0]));
        end
      end
      if (fd[g] === 1'b1) fdcnt++;
    end
  end

  task automatic push(input int g, input logic [11:0] a,
                      input logic [31:0] d);
    sb[g].push_back({a, d});
  endtask

  task automatic check_zero(input int g, input string tag);
    chk({tag, "_ready"}, 64'(rdy[g]), 64'd0);
    chk({tag, "_wea"}, 64'(wea_v[g]), 64'd0);
    chk({tag, "_busy"}, 64'(bsy[g]), 64'd0);
    chk({tag, "_done"}, 64'(fd[g]), 64'd0);
    chk({tag, "_addr"}, 64'(adr[g]), 64'd0);
    chk({tag, "_din"}, 64'(din[g]), 64'd0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    pix_valid = 1'b0;
    pause = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int g);
    @(negedge clk);
    pause = 1'b0;
    pix_valid = 1'b0;
    st[g] = 1'b1;
    @(negedge clk);
    st[g] = 1'b0;
    chk("start_busy", 64'(bsy[g]), 64'd1);
    chk("start_ready", 64'(rdy[g]), 64'd1);
  endtask

  task automatic send(input int g, input logic [7:0] p, input bit rnd);
    int n = 0;
    bit done = 0;
    logic r;
    while (!done) begin
      @(negedge clk);
      pause = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_in = p;
      #1;
      r = rdy[g];
      if (pause) chk("ready_paused", 64'(r), 64'd0);
      @(posedge clk);
      if (pix_valid && r) done = 1;
      n++;
      if (!done && n > 200) begin
        chk("accept_timeout", 64'd1, 64'd0);
        done = 1;
      end
    end
  endtask

  task automatic push_basic();
    push(0, 12'd0, 32'h44332211);
    push(0, 12'd1, 32'h88776655);
  endtask

  logic [7:0] b;

  initial begin
    #3;
    for (int g = 0; g < 3; g++) check_zero(g, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    // valid without start must not be taken
    pix_valid = 1'b1;
    pix_in = 8'h5a;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", 64'(rdy[0]), 64'd0);
    end

    // basic frame with exact completion timing
    do_start(0);
    push_basic();
    for (int i = 1; i <= 8; i++) send(0, 8'(i * 8'h11), 1'b0);
    @(negedge clk);
    pix_valid = 1'b0;
    chk("L1_wea", 64'(wea_v[0]), 64'd1);
    chk("L1_done", 64'(fd[0]), 64'd0);
    chk("L1_addr", 64'(adr[0]), 64'd1);
    @(negedge clk);
    chk("L2_done", 64'(fd[0]), 64'd1);
    chk("L2_busy", 64'(bsy[0]), 64'd1);
    chk("L2_wea", 64'(wea_v[0]), 64'd0);
    @(negedge clk);
    chk("L3_busy", 64'(bsy[0]), 64'd0);
    chk("L3_done", 64'(fd[0]), 64'd0);
    chk("basic_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("basic_fd_count", 64'(mon[0].fdcnt), 64'd1);

    // partial final word
    do_start(1);
    push(1, 12'd0, 32'h04030201);
    push(1, 12'd1, 32'h00000605);
    for (int i = 1; i <= 6; i++) send(1, 8'(i), 1'b0);
    idle(4);
    chk("partial_sb_empty", 64'(sb[1].size()), 64'd0);
    chk("partial_fd_count", 64'(mon[1].fdcnt), 64'd1);

    // random pause and valid gaps
    do_start(0);
    push_basic();
    for (int i = 1; i <= 8; i++) send(0, 8'(i * 8'h11), 1'b1);
    idle(4);
    chk("pause_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("pause_fd_count", 64'(mon[0].fdcnt), 64'd2);

    // start while busy is ignored
    do_start(0);
    push_basic();
    for (int i = 1; i <= 3; i++) send(0, 8'(i * 8'h11), 1'b0);
    @(negedge clk);
    pix_valid = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    for (int i = 4; i <= 8; i++) send(0, 8'(i * 8'h11), 1'b0);
    idle(4);
    chk("rearm_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("rearm_fd_count", 64'(mon[0].fdcnt), 64'd3);

    // reset mid-frame discards the partial word
    do_start(0);
    push(0, 12'd0, 32'h44332211);
    for (int i = 1; i <= 5; i++) send(0, 8'(i * 8'h11), 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero(0, "abort");
    @(negedge clk);
    reset_n = 1'b1;
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_ready", 64'(rdy[0]), 64'd0);
    end
    do_start(0);
    push_basic();
    for (int i = 1; i <= 8; i++) send(0, 8'(i * 8'h11), 1'b0);
    idle(4);
    chk("abort_sb_empty", 64'(sb[0].size()), 64'd0);
    chk("abort_fd_count", 64'(mon[0].fdcnt), 64'd4);
    chk("u8_wea_count", 64'(mon[0].wcnt), 64'd9);

    // full default frame
    do_start(2);
    for (int k = 0; k < 4096; k++) begin
      b = 8'(4 * k);
      push(2, 12'(k), {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    for (int i = 0; i < 16384; i++) send(2, 8'(i), 1'b0);
    idle(4);
    chk("full_wea_count", 64'(mon[2].wcnt), 64'd4096);
    chk("full_fd_count", 64'(mon[2].fdcnt), 64'd1);
    chk("full_sb_empty", 64'(sb[2].size()), 64'd0);
    chk("full_idle", 64'(bsy[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
